// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, color type and rectangle-fill FSM states
package vga_pkg;
   localparam int SCALE            = 5;
   localparam int BITS_PER_CHANNEL = 1;
   localparam int WIDTH            = 1680 / SCALE;
   localparam int HEIGHT           = 1050 / SCALE;
   localparam int WIDTH2           = $clog2(WIDTH);
   localparam int HEIGHT2          = $clog2(HEIGHT);
   typedef logic [2:0][BITS_PER_CHANNEL-1:0] color_t;
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;
endpackage

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: raster-order solid rectangle filler driving a VGA adapter pixel port
module vga_rect_fill
   import vga_pkg::*;
#(
   parameter int BITS_PER_CHANNEL = 1,
   parameter int WIDTH            = 336,
   parameter int HEIGHT           = 210,
   parameter int WIDTH2           = $clog2(WIDTH),
   parameter int HEIGHT2          = $clog2(HEIGHT)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          i_start,
   output logic                          o_ready,
   input  logic [WIDTH2-1:0]             i_x0,
   input  logic [WIDTH2-1:0]             i_x1,
   input  logic [HEIGHT2-1:0]            i_y0,
   input  logic [HEIGHT2-1:0]            i_y1,
   input  logic [3*BITS_PER_CHANNEL-1:0] i_color,
   output logic [WIDTH2-1:0]             x,
   output logic [HEIGHT2-1:0]            y,
   output logic [3*BITS_PER_CHANNEL-1:0] color,
   output logic                          plot,
   output logic                          o_done
);
   localparam logic [WIDTH2-1:0]  X_MAX = WIDTH2'(WIDTH - 1);
   localparam logic [HEIGHT2-1:0] Y_MAX = HEIGHT2'(HEIGHT - 1);

   logic [1:0]                    r_rst_sync;
   logic                          w_rst_n;
   state_t                        r_state;
   logic [WIDTH2-1:0]             r_x0, r_x1, r_xl, r_xr, r_x;
   logic [HEIGHT2-1:0]            r_y0, r_y1, r_yt, r_yb, r_y;
   logic [3*BITS_PER_CHANNEL-1:0] r_color;
   logic [WIDTH2-1:0]             w_xl, w_xr;
   logic [HEIGHT2-1:0]            w_yt, w_yb;

   // Reset asserts at once, releases two clk edges later
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_rst_sync <= '0;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   assign w_rst_n = r_rst_sync[1];

   // Order each corner pair, then clamp both ends onto the visible area
   always_comb begin
      w_xl = (r_x0 < r_x1) ? r_x0 : r_x1;
      w_xr = (r_x0 < r_x1) ? r_x1 : r_x0;
      w_yt = (r_y0 < r_y1) ? r_y0 : r_y1;
      w_yb = (r_y0 < r_y1) ? r_y1 : r_y0;
      w_xl = (w_xl > X_MAX) ? X_MAX : w_xl;
      w_xr = (w_xr > X_MAX) ? X_MAX : w_xr;
      w_yt = (w_yt > Y_MAX) ? Y_MAX : w_yt;
      w_yb = (w_yb > Y_MAX) ? Y_MAX : w_yb;
   end

   // Request capture, bound setup and raster walk; counters wrap by compare, never by overflow
   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_state <= S_IDLE;
         r_x0    <= '0;
         r_x1    <= '0;
         r_y0    <= '0;
         r_y1    <= '0;
         r_xl    <= '0;
         r_xr    <= '0;
         r_yt    <= '0;
         r_yb    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_color <= '0;
      end else begin
         case (r_state)
            S_IDLE:
               if (i_start) begin
                  r_x0    <= i_x0;
                  r_x1    <= i_x1;
                  r_y0    <= i_y0;
                  r_y1    <= i_y1;
                  r_color <= i_color;
                  r_state <= S_SETUP;
               end
            S_SETUP: begin
               r_xl    <= w_xl;
               r_xr    <= w_xr;
               r_yt    <= w_yt;
               r_yb    <= w_yb;
               r_x     <= w_xl;
               r_y     <= w_yt;
               r_state <= S_FILL;
            end
            S_FILL:
               if (r_x == r_xr) begin
                  r_x <= r_xl;
                  if (r_y == r_yb) r_state <= S_DONE;
                  else             r_y <= r_y + 1'b1;
               end else begin
                  r_x <= r_x + 1'b1;
               end
            default: r_state <= S_IDLE;
         endcase
      end

   assign o_ready = (r_state == S_IDLE);
   assign plot    = (r_state == S_FILL);
   assign o_done  = (r_state == S_DONE);
   assign x       = r_x;
   assign y       = r_y;
   assign color   = r_color;
endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed and random rectangle fills checked against a pixel-list model
module tb_vga_rect_fill;
   localparam int W  = 336;
   localparam int H  = 210;
   localparam int WB = 9;
   localparam int HB = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_start = 1'b0;
   logic          o_ready;
   logic [WB-1:0] i_x0 = '0, i_x1 = '0, x;
   logic [HB-1:0] i_y0 = '0, i_y1 = '0, y;
   logic [2:0]    i_color = '0, color;
   logic          plot, o_done;
   int            tests = 0;
   int            fails = 0;

   vga_rect_fill dut (
      .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_ready(o_ready),
      .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1), .i_color(i_color),
      .x(x), .y(y), .color(color), .plot(plot), .o_done(o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected pixels are the clamped bounding box listed row by row
   task automatic run_fill(input int x0, input int x1, input int y0, input int y1,
                           input logic [2:0] col, input bit hold);
      int xl, xr, yt, yb;
      logic [19:0] q[$];
      xl = (x0 < x1) ? x0 : x1;
      xr = (x0 < x1) ? x1 : x0;
      yt = (y0 < y1) ? y0 : y1;
      yb = (y0 < y1) ? y1 : y0;
      if (xl > W - 1) xl = W - 1;
      if (xr > W - 1) xr = W - 1;
      if (yt > H - 1) yt = H - 1;
      if (yb > H - 1) yb = H - 1;
      for (int yy = yt; yy <= yb; yy++)
         for (int xx = xl; xx <= xr; xx++)
            q.push_back({WB'(xx), HB'(yy), col});
      @(negedge clk);
      check("ready_before", o_ready, 1);
      i_x0 = WB'(x0); i_x1 = WB'(x1); i_y0 = HB'(y0); i_y1 = HB'(y1);
      i_color = col;
      i_start = 1'b1;
      @(negedge clk);
      i_start = hold;
      i_color = ~col;
      check("setup_idle_out", {o_ready, plot, o_done}, 3'b000);
      foreach (q[i]) begin
         @(negedge clk);
         check($sformatf("pixel%0d(%0d,%0d)-(%0d,%0d)", i, x0, y0, x1, y1),
               {plot, o_done, x, y, color}, {2'b10, q[i]});
      end
      @(negedge clk);
      check("done_pulse", {o_done, plot, o_ready}, 3'b100);
      i_start = 1'b0;
      @(negedge clk);
      check("ready_after", {o_ready, o_done, plot}, 3'b100);
      if (hold) begin
         @(negedge clk);
         check("no_restart", {o_ready, plot, o_done}, 3'b100);
      end
   endtask

   initial begin
      int bx, by, ex, ey;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {o_ready, plot, o_done, x, y, color}, {3'b100, 20'd0});
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_release_idle", {o_ready, plot, o_done}, 3'b100);

      run_fill(2, 4, 3, 4, 3'b101, 1'b0);
      run_fill(4, 2, 4, 3, 3'b101, 1'b0);
      run_fill(330, 400, 205, 250, 3'b011, 1'b0);
      run_fill(7, 7, 7, 7, 3'b110, 1'b1);

      for (int t = 0; t < 8; t++) begin
         bx = $urandom_range(0, 511);
         by = $urandom_range(0, 255);
         ex = bx + $urandom_range(0, 10);
         ey = by + $urandom_range(0, 6);
         if (ex > 511) ex = 511;
         if (ey > 255) ey = 255;
         if ($urandom_range(0, 1) == 1) run_fill(ex, bx, by, ey, 3'($urandom), 1'b0);
         else                           run_fill(bx, ex, ey, by, 3'($urandom), 1'b0);
      end

      // Abort a 10x10 fill on its tenth pixel
      @(negedge clk);
      i_x0 = 0; i_x1 = 9; i_y0 = 0; i_y1 = 9; i_color = 3'b111;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("abort_pixel%0d", i), {plot, x, y}, {1'b1, WB'(i), HB'(0)});
      end
      reset_n = 1'b0;
      #1;
      check("abort_immediate", {plot, o_done, o_ready}, 3'b001);
      repeat (3) begin
         @(negedge clk);
         check("abort_held", {plot, o_done}, 2'b00);
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("abort_release", {plot, o_done}, 2'b00);
      end
      check("abort_ready", o_ready, 1);

      run_fill(0, W - 1, 0, H - 1, 3'b010, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter BITS_PER_CHANNEL, default 1, bits per color channel.
REQ-002 SHALL have parameter WIDTH, default 336, visible columns (1680/5).
REQ-003 SHALL have parameter HEIGHT, default 210, visible rows (1050/5).
REQ-004 SHALL have parameters WIDTH2 = clog2(WIDTH) and HEIGHT2 = clog2(HEIGHT), the coordinate widths.
REQ-005 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock, 50 MHz board clock.
- reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have these request ports:
- i_start  in  1  request valid.
- o_ready  out  1  block idle; request accepted when i_start && o_ready.
- i_x0, i_x1  in  WIDTH2 each  column corners.
- i_y0, i_y1  in  HEIGHT2 each  row corners.
- i_color  in  3xBITS_PER_CHANNEL  fill color.
REQ-007 SHALL have these pixel and status outputs:
- x  out  WIDTH2  pixel column, to adapter x.
- y  out  HEIGHT2  pixel row, to adapter y.
- color  out  3xBITS_PER_CHANNEL  pixel color, to adapter color.
- plot  out  1  pixel write strobe, to adapter plot.
- o_done  out  1  one-cycle completion pulse.

Function
REQ-008 SHALL implement FSM IDLE -> SETUP -> FILL -> DONE -> IDLE.
REQ-009 IDLE: o_ready=1. On i_start, SHALL register x0, x1, y0, y1 and color, then go to SETUP.
REQ-010 SETUP (1 cycle): SHALL swap each corner pair so that xl<=xr and yt<=yb.
REQ-011 SETUP: SHALL clamp xr to WIDTH-1 and yb to HEIGHT-1, and also clamp xl and yt to the same limits.
REQ-012 SETUP: SHALL load the x and y counters with xl and yt.
REQ-013 FILL: SHALL assert plot every cycle and emit pixels in raster order.
- x increments each cycle.
- At x==xr: x wraps to xl and y increments.
- On the cycle x==xr && y==yb: plot is asserted, then the FSM goes to DONE.
REQ-014 Total plot cycles SHALL equal (xr-xl+1)*(yb-yt+1), with no gaps and no duplicate pixels.
REQ-015 First plot SHALL occur 2 cycles after the accepting edge: accept in IDLE, SETUP, then first FILL cycle.
REQ-016 DONE (1 cycle): SHALL assert o_done=1 with plot=0, then return to IDLE.
- o_ready SHALL be 1 again the cycle after DONE.
REQ-017 color SHALL hold the registered request color for the whole of FILL.
- i_color changes after acceptance SHALL have no effect.
REQ-018 Outside FILL: plot SHALL be 0.
- x, y and color SHALL hold their last values (don't-care to the adapter).
REQ-019 i_start while o_ready=0 SHALL be ignored, not queued.
REQ-020 Single-pixel request (x0==x1, y0==y1) SHALL produce exactly one plot cycle, then DONE.
REQ-021 A full-screen request (0,0)-(WIDTH-1,HEIGHT-1) SHALL wrap without counter overflow.
- Counters are WIDTH2 and HEIGHT2 bits wide.
- Compare-to-bound is used, never natural overflow.

Reset
REQ-022 Assertion of reset_n=0 SHALL take effect immediately (asynchronously).
REQ-023 Reset values SHALL be:
- FSM = IDLE, o_ready=1, plot=0, o_done=0.
- x=0, y=0, color=0.
REQ-024 Reset mid-FILL SHALL abort the fill with no further plot and no o_done pulse.
REQ-025 Deassertion SHALL be synchronised to clk by a two-flop reset_n synchroniser inside the block.

Structure
REQ-026 A shared package vga_pkg SHALL hold the following, reused by the vga adapter and the LDA:
- Constants SCALE=5, WIDTH, HEIGHT, WIDTH2, HEIGHT2.
- The color_t typedef (logic [2:0][BITS_PER_CHANNEL-1:0]).
- The FSM state enum.
REQ-027 The block SHALL be a single flat module with no sub-modules.
- Corner swap/clamp is inline combinational logic registered in SETUP.

Verification
REQ-028 Rect (2,3)-(4,4), color 3'b101 -> 6 plots in order (2,3) (3,3) (4,3) (2,4) (3,4) (4,4), all color 101, then one o_done.
REQ-029 Swapped corners (4,4)-(2,3) -> identical 6-pixel sequence to REQ-028.
REQ-030 Clamp (330,205)-(400,250) -> x in 330..335, y in 205..209, 30 plots, then o_done.
REQ-031 Single pixel (7,7) -> exactly one plot cycle, first plot at accept+2, o_done at accept+3; i_start held high during busy -> no second fill.
REQ-032 Full screen (0,0)-(335,209) -> 70560 plots, last (335,209), o_ready back the cycle after o_done.
REQ-033 Assert reset_n=0 at the 10th plot of (0,0)-(9,9) -> plot=0 immediately, no o_done, o_ready=1 after release.
